// File: rtl/register_file_r_pkg.sv
// Shared defaults and elaboration helpers for the resettable register file.
package register_file_r_pkg;

   localparam int unsigned RF_WIDTH = 4;
   localparam int unsigned RF_DEPTH = 8;
   localparam int unsigned RF_AW    = 3;

   // Smallest r with 2**r >= n; used to size address fields from a depth.
   function automatic int rf_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/register_file_r_if.sv
// Write/read bus of the register file; the owner of the storage is the slave.
interface register_file_r_if
   import register_file_r_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = rf_clog2(DEPTH)
);

   logic             clr;
   logic             we;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr0;
   logic [WIDTH-1:0] rd_data0;
   logic             rd_vld0;
   logic [AW-1:0]    rd_addr1;
   logic [WIDTH-1:0] rd_data1;
   logic             rd_vld1;
   logic [DEPTH-1:0] vld_vec;

   modport master (
      output clr, we, wr_addr, wr_data, rd_addr0, rd_addr1,
      input  rd_data0, rd_vld0, rd_data1, rd_vld1, vld_vec
   );

   modport slave (
      input  clr, we, wr_addr, wr_data, rd_addr0, rd_addr1,
      output rd_data0, rd_vld0, rd_data1, rd_vld1, vld_vec
   );

endinterface

// File: rtl/register_file_r_en.sv
// Single register with load enable and synchronous clear; clear wins over load.
module register_en_r #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Async reset, then sync clear, then enabled load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file_r.sv
// DEPTH x WIDTH register file with per-entry valid bits, one write port,
// two combinational read ports and optional write-to-read forwarding.
module register_file_r
   import register_file_r_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int AW     = rf_clog2(DEPTH),
   parameter bit BYPASS = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   register_file_r_if.slave   bus
);

   logic [DEPTH-1:0] wr_en;
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] ent [DEPTH];
   logic             wr_in_rng;
   logic             rd0_in_rng;
   logic             rd1_in_rng;
   logic [WIDTH-1:0] st_d0;
   logic [WIDTH-1:0] st_d1;
   logic             st_v0;
   logic             st_v1;

   // Non-power-of-two depths leave holes in the address space; those are inert.
   assign wr_in_rng  = 32'(bus.wr_addr)  < 32'(DEPTH);
   assign rd0_in_rng = 32'(bus.rd_addr0) < 32'(DEPTH);
   assign rd1_in_rng = 32'(bus.rd_addr1) < 32'(DEPTH);

   // One-hot write decode; clr is handled inside each register so it dominates.
   always_comb begin
      wr_en = '0;
      if (bus.we && wr_in_rng) begin
         wr_en[bus.wr_addr] = 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      register_en_r #(.WIDTH(WIDTH)) u_data (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (bus.clr),
         .en      (wr_en[i]),
         .d       (bus.wr_data),
         .q       (ent[i])
      );

      register_en_r #(.WIDTH(1)) u_vld (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (bus.clr),
         .en      (wr_en[i]),
         .d       (1'b1),
         .q       (vld[i])
      );
   end

   // Stored-value read muxes; out-of-range addresses read as empty.
   always_comb begin
      st_d0 = '0;
      st_v0 = 1'b0;
      st_d1 = '0;
      st_v1 = 1'b0;
      if (rd0_in_rng) begin
         st_d0 = ent[bus.rd_addr0];
         st_v0 = vld[bus.rd_addr0];
      end
      if (rd1_in_rng) begin
         st_d1 = ent[bus.rd_addr1];
         st_v1 = vld[bus.rd_addr1];
      end
   end

   if (BYPASS) begin : g_byp
      logic fwd0;
      logic fwd1;

      // A write that is about to land is shown early; a clear suppresses it.
      assign fwd0 = bus.we && !bus.clr && wr_in_rng && (bus.wr_addr == bus.rd_addr0);
      assign fwd1 = bus.we && !bus.clr && wr_in_rng && (bus.wr_addr == bus.rd_addr1);

      assign bus.rd_data0 = fwd0 ? bus.wr_data : st_d0;
      assign bus.rd_vld0  = fwd0 | st_v0;
      assign bus.rd_data1 = fwd1 ? bus.wr_data : st_d1;
      assign bus.rd_vld1  = fwd1 | st_v1;
   end else begin : g_nobyp
      assign bus.rd_data0 = st_d0;
      assign bus.rd_vld0  = st_v0;
      assign bus.rd_data1 = st_d1;
      assign bus.rd_vld1  = st_v1;
   end

   assign bus.vld_vec = vld;

endmodule

// File: tb/tb_register_file_r.sv
// Bench for register_file_r: instance A (DEPTH=8, no forwarding) and
// instance B (DEPTH=6, forwarding) share one stimulus stream.
module tb_register_file_r;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clr = 1'b0;
   logic       we = 1'b0;
   logic [2:0] wa = '0;
   logic [3:0] wd = '0;
   logic [2:0] ra0 = '0;
   logic [2:0] ra1 = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   register_file_r_if #(.WIDTH(4), .DEPTH(8), .AW(3)) bus_a ();
   register_file_r_if #(.WIDTH(4), .DEPTH(6), .AW(3)) bus_b ();

   assign bus_a.clr = clr;      assign bus_b.clr = clr;
   assign bus_a.we = we;        assign bus_b.we = we;
   assign bus_a.wr_addr = wa;   assign bus_b.wr_addr = wa;
   assign bus_a.wr_data = wd;   assign bus_b.wr_data = wd;
   assign bus_a.rd_addr0 = ra0; assign bus_b.rd_addr0 = ra0;
   assign bus_a.rd_addr1 = ra1; assign bus_b.rd_addr1 = ra1;

   register_file_r #(.WIDTH(4), .DEPTH(8), .AW(3), .BYPASS(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
   register_file_r #(.WIDTH(4), .DEPTH(6), .AW(3), .BYPASS(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

   logic [3:0] act_d0 [2];
   logic [3:0] act_d1 [2];
   logic       act_v0 [2];
   logic       act_v1 [2];
   logic [7:0] act_vv [2];
   assign act_d0[0] = bus_a.rd_data0; assign act_d0[1] = bus_b.rd_data0;
   assign act_d1[0] = bus_a.rd_data1; assign act_d1[1] = bus_b.rd_data1;
   assign act_v0[0] = bus_a.rd_vld0;  assign act_v0[1] = bus_b.rd_vld0;
   assign act_v1[0] = bus_a.rd_vld1;  assign act_v1[1] = bus_b.rd_vld1;
   assign act_vv[0] = bus_a.vld_vec;  assign act_vv[1] = {2'b00, bus_b.vld_vec};

   // Reference model: plain arrays of what each instance should hold.
   int         dep [2] = '{8, 6};
   bit         byp [2] = '{1'b0, 1'b1};
   logic [3:0] m_d [2][8];
   bit         m_v [2][8];

   task automatic model_clear();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) begin
            m_d[k][i] = '0;
            m_v[k][i] = 1'b0;
         end
   endtask

   function automatic void exp_rd(input int k, input int a, output logic [3:0] d, output logic v);
      if (a >= dep[k]) begin
         d = '0; v = 1'b0;
      end else if (byp[k] && we && !clr && int'(wa) == a) begin
         d = wd; v = 1'b1;
      end else begin
         d = m_d[k][a]; v = m_v[k][a];
      end
   endfunction

   function automatic logic [7:0] exp_vv(input int k);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < dep[k]; i++) r[i] = m_v[k][i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] d;
      logic       v;
      for (int k = 0; k < 2; k++) begin
         exp_rd(k, int'(ra0), d, v);
         chk($sformatf("%s inst%0d rd_data0", tag, k), 32'(act_d0[k]), 32'(d));
         chk($sformatf("%s inst%0d rd_vld0", tag, k), 32'(act_v0[k]), 32'(v));
         exp_rd(k, int'(ra1), d, v);
         chk($sformatf("%s inst%0d rd_data1", tag, k), 32'(act_d1[k]), 32'(d));
         chk($sformatf("%s inst%0d rd_vld1", tag, k), 32'(act_v1[k]), 32'(v));
         chk($sformatf("%s inst%0d vld_vec", tag, k), 32'(act_vv[k]), 32'(exp_vv(k)));
      end
   endtask

   task automatic drive(input logic c, input logic w, input logic [2:0] a, input logic [3:0] d,
                        input logic [2:0] r0, input logic [2:0] r1);
      clr = c; we = w; wa = a; wd = d; ra0 = r0; ra1 = r1;
      #2;
   endtask

   // One rising edge; the model follows the priority reset > clr > in-range write.
   task automatic tick();
      @(posedge clk);
      if (!reset_n || clr) model_clear();
      else if (we) begin
         for (int k = 0; k < 2; k++)
            if (int'(wa) < dep[k]) begin
               m_d[k][wa] = wd;
               m_v[k][wa] = 1'b1;
            end
      end
      #1;
   endtask

   typedef struct {
      logic            clr, we;
      logic [2:0]      wa;
      logic [3:0]      wd;
      logic [2:0]      ra0, ra1;
      logic [1:0][3:0] ed0, ed1;
      logic [1:0]      ev0, ev1;
      logic [1:0][7:0] evv;
   } vec_t;

   function automatic vec_t mk(input logic c, input logic w, input logic [2:0] a, input logic [3:0] d,
                               input logic [2:0] r0, input logic [2:0] r1,
                               input logic [3:0] a_d0, input logic a_v0, input logic [3:0] a_d1,
                               input logic a_v1, input logic [7:0] a_vv,
                               input logic [3:0] b_d0, input logic b_v0, input logic [3:0] b_d1,
                               input logic b_v1, input logic [7:0] b_vv);
      vec_t v;
      v.clr = c; v.we = w; v.wa = a; v.wd = d; v.ra0 = r0; v.ra1 = r1;
      v.ed0[0] = a_d0; v.ev0[0] = a_v0; v.ed1[0] = a_d1; v.ev1[0] = a_v1; v.evv[0] = a_vv;
      v.ed0[1] = b_d0; v.ev0[1] = b_v0; v.ed1[1] = b_d1; v.ev1[1] = b_v1; v.evv[1] = b_vv;
      return v;
   endfunction

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Rows are checked before their edge; expectations follow from earlier rows.
      tbl[0] = mk(0,1,3,4'hA,3,2, 4'h0,0,4'h0,0,8'h00, 4'hA,1,4'h0,0,8'h00);
      tbl[1] = mk(0,0,3,4'hA,3,2, 4'hA,1,4'h0,0,8'h08, 4'hA,1,4'h0,0,8'h08);
      tbl[2] = mk(0,1,5,4'h1,5,3, 4'h0,0,4'hA,1,8'h08, 4'h1,1,4'hA,1,8'h08);
      tbl[3] = mk(0,1,5,4'h6,5,5, 4'h1,1,4'h1,1,8'h28, 4'h6,1,4'h6,1,8'h28);
      tbl[4] = mk(0,1,4,4'hC,4,5, 4'h0,0,4'h6,1,8'h28, 4'hC,1,4'h6,1,8'h28);
      tbl[5] = mk(0,0,4,4'hC,4,4, 4'hC,1,4'hC,1,8'h38, 4'hC,1,4'hC,1,8'h38);
      tbl[6] = mk(0,1,7,4'hF,7,6, 4'h0,0,4'h0,0,8'h38, 4'h0,0,4'h0,0,8'h38);
      tbl[7] = mk(0,0,7,4'hF,7,6, 4'hF,1,4'h0,0,8'hB8, 4'h0,0,4'h0,0,8'h38);
      tbl[8] = mk(1,1,2,4'h9,2,4, 4'h0,0,4'hC,1,8'hB8, 4'h0,0,4'hC,1,8'h38);
      tbl[9] = mk(0,0,2,4'h9,2,4, 4'h0,0,4'h0,0,8'h00, 4'h0,0,4'h0,0,8'h00);

      model_clear();

      // Power-on reset state.
      drive(0, 0, 3'd0, 4'h0, 3'd3, 3'd5);
      tick();
      check_model("por");
      for (int k = 0; k < 2; k++) chk($sformatf("por inst%0d vld_vec zero", k), 32'(act_vv[k]), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // Fill every entry, then a 3 ns reset pulse between edges.
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 3'(i), 4'(i + 1), 3'(i), 3'd0);
         tick();
      end
      drive(0, 0, 3'd0, 4'h0, 3'd3, 3'd5);
      check_model("filled");
      reset_n = 1'b0;
      #1;
      model_clear();
      check_model("rst_low");
      for (int k = 0; k < 2; k++) chk($sformatf("rst_low inst%0d vld_vec", k), 32'(act_vv[k]), 32'h0);
      #2;
      reset_n = 1'b1;
      #1;
      check_model("rst_released");
      tick();

      // Reset held across an edge while a write is presented: the write is lost.
      drive(0, 1, 3'd1, 4'h7, 3'd1, 3'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      drive(0, 0, 3'd1, 4'h7, 3'd1, 3'd1);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_abort inst%0d vld_vec", k), 32'(act_vv[k]), 32'h0);
         chk($sformatf("rst_abort inst%0d rd_data0", k), 32'(act_d0[k]), 32'h0);
      end
      check_model("rst_abort");

      // Directed table.
      for (int r = 0; r < 10; r++) begin
         drive(tbl[r].clr, tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].ra0, tbl[r].ra1);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("row%0d inst%0d rd_data0", r, k), 32'(act_d0[k]), 32'(tbl[r].ed0[k]));
            chk($sformatf("row%0d inst%0d rd_vld0", r, k),  32'(act_v0[k]), 32'(tbl[r].ev0[k]));
            chk($sformatf("row%0d inst%0d rd_data1", r, k), 32'(act_d1[k]), 32'(tbl[r].ed1[k]));
            chk($sformatf("row%0d inst%0d rd_vld1", r, k),  32'(act_v1[k]), 32'(tbl[r].ev1[k]));
            chk($sformatf("row%0d inst%0d vld_vec", r, k),  32'(act_vv[k]), 32'(tbl[r].evv[k]));
         end
         tick();
      end

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
               3'($urandom_range(0, 7)), 4'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         check_model($sformatf("rnd%0d", n));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
